// File: rtl/bb_reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and counter sizing.
package bb_reset_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    function automatic int CNT_W(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/bb_reset_sync_core.sv
// Async-assert, sync-deassert reset synchroniser of STAGE_NUM flops.
module bb_reset_sync_core #(
    parameter int STAGE_NUM = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [STAGE_NUM-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[STAGE_NUM-2:0], 1'b1};
    end

    assign sync_rst_n = r_sync[STAGE_NUM-1];

endmodule

// File: rtl/bb_reset_seq.sv
// Multi-channel reset sequencer: all outputs assert together, release in index
// order after a minimum hold, restartable by a synchronous software request.
module bb_reset_seq
    import bb_reset_pkg::*;
#(
    parameter int STAGE_NUM  = 2,
    parameter int CH_NUM     = 4,
    parameter int MIN_ASSERT = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst_req,
    output logic [CH_NUM-1:0] gen_rst_n,
    output logic              seq_busy,
    output logic              seq_done
);

    localparam int CW    = CNT_W(MIN_ASSERT, GAP_CYC);
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    localparam logic [CW-1:0]    L_MA   = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0]    L_GAP  = CW'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] L_LAST = IDX_W'(CH_NUM - 1);

    logic w_sync;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt,   w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
    logic [CH_NUM-1:0]   r_gen,   w_gen_nxt;

    bb_reset_sync_core #(
        .STAGE_NUM (STAGE_NUM)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_gen   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_gen   <= w_gen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_gen_nxt   = r_gen;

        case (r_state)
            // HOLD with the sync reset high behaves as the first STRETCH cycle
            // (counter already 0), so ch0 releases MIN_ASSERT edges after the sync edge.
            HOLD, STRETCH: begin
                if (r_state != HOLD && sw_rst_req) begin
                    w_gen_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = STRETCH;
                end else if (w_sync) begin
                    if (r_cnt == L_MA) begin
                        w_gen_nxt[0] = 1'b1;
                        w_cnt_nxt    = '0;
                        w_idx_nxt    = IDX_W'(1);
                        w_state_nxt  = (CH_NUM == 1) ? RUN : RELEASE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = STRETCH;
                    end
                end
            end
            RELEASE: begin
                if (sw_rst_req) begin
                    w_gen_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = STRETCH;
                end else if (r_cnt == L_GAP) begin
                    for (int unsigned i = 1; i < CH_NUM; i++) begin
                        if (r_idx == IDX_W'(i)) w_gen_nxt[i] = 1'b1;
                    end
                    w_cnt_nxt = '0;
                    if (r_idx == L_LAST) w_state_nxt = RUN;
                    else                 w_idx_nxt   = r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    w_gen_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = STRETCH;
                end
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    assign gen_rst_n = r_gen;
    assign seq_done  = (r_state == RUN);
    assign seq_busy  = (r_state != RUN);

endmodule

// File: tb/tb_bb_reset_seq.sv
// Directed bench for bb_reset_seq: main config (2,3,4,2) plus a (3,1,1,1) sweep instance.
module tb_bb_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] gen_rst_n;
    logic       seq_busy, seq_done;

    logic       rst2_n = 1'b0;
    logic       sw2 = 1'b0;
    logic [0:0] gen2;
    logic       busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bb_reset_seq #(
        .STAGE_NUM (2), .CH_NUM (3), .MIN_ASSERT (4), .GAP_CYC (2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .sw_rst_req (sw_rst_req),
        .gen_rst_n (gen_rst_n), .seq_busy (seq_busy), .seq_done (seq_done)
    );

    bb_reset_seq #(
        .STAGE_NUM (3), .CH_NUM (1), .MIN_ASSERT (1), .GAP_CYC (1)
    ) dut2 (
        .clk (clk), .rst_n (rst2_n), .sw_rst_req (sw2),
        .gen_rst_n (gen2), .seq_busy (busy2), .seq_done (done2)
    );

    // Release edges for config (2,3,4,2): event edge + 4 + 2*i. Event is edge 2
    // (sync release) before any sw request, else the last sw-request edge.
    function automatic logic [2:0] exp3(input int e, input int swf, input int swl);
        int base;
        logic [2:0] r;
        base = (swf == 0 || e < swf) ? 2 : swl;
        for (int i = 0; i < 3; i++) r[i] = (e >= base + 4 + 2 * i);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic restart_main;
        rst_n = 1'b0;
        sw_rst_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if ((gen_rst_n[1] && !gen_rst_n[0]) || (gen_rst_n[2] && !gen_rst_n[1])) begin
            n_fail++;
            $display("FAIL monotonic: gen_rst_n=%b", gen_rst_n);
        end
    end

    task automatic test_reset;
        #2;
        n_tests++;
        if (gen_rst_n !== 3'b000 || seq_busy !== 1'b1 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: gen=%b busy=%b done=%b, want 000 1 0", gen_rst_n, seq_busy, seq_done);
        end
        n_tests++;
        if (gen2 !== 1'b0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset2: gen=%b busy=%b done=%b, want 0 1 0", gen2, busy2, done2);
        end
    endtask

    task automatic test_power_on;
        logic [2:0] exp;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp = exp3(e, 0, 0);
            n_tests++;
            if (gen_rst_n !== exp || seq_done !== exp[2] || seq_busy !== !exp[2]) begin
                n_fail++;
                $display("FAIL power_on edge %0d: gen=%b done=%b busy=%b, want gen=%b done=%b",
                         e, gen_rst_n, seq_done, seq_busy, exp, exp[2]);
            end
        end
    endtask

    task automatic test_async_mid;
        logic [2:0] exp;
        restart_main();
        for (int e = 1; e <= 7; e++) tick();
        n_tests++;
        if (gen_rst_n !== 3'b001) begin
            n_fail++;
            $display("FAIL async_pre: gen=%b, want 001", gen_rst_n);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (gen_rst_n !== 3'b000 || seq_done !== 1'b0 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_drop: gen=%b done=%b busy=%b, want 000 0 1", gen_rst_n, seq_done, seq_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp = exp3(e, 0, 0);
            n_tests++;
            if (gen_rst_n !== exp || seq_done !== exp[2]) begin
                n_fail++;
                $display("FAIL async_rerun edge %0d: gen=%b done=%b, want gen=%b done=%b",
                         e, gen_rst_n, seq_done, exp, exp[2]);
            end
        end
    endtask

    task automatic test_sw_single;
        logic [2:0] exp;
        restart_main();
        for (int e = 1; e <= 30; e++) begin
            sw_rst_req = (e == 20);
            tick();
            exp = exp3(e, 20, 20);
            n_tests++;
            if (gen_rst_n !== exp || seq_done !== exp[2] || seq_busy !== !exp[2]) begin
                n_fail++;
                $display("FAIL sw_single edge %0d: gen=%b done=%b busy=%b, want gen=%b done=%b",
                         e, gen_rst_n, seq_done, seq_busy, exp, exp[2]);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_sw_early;
        logic [2:0] exp;
        restart_main();
        for (int e = 1; e <= 16; e++) begin
            sw_rst_req = (e == 7);
            tick();
            exp = exp3(e, 7, 7);
            n_tests++;
            if (gen_rst_n !== exp || seq_done !== exp[2]) begin
                n_fail++;
                $display("FAIL sw_early edge %0d: gen=%b done=%b, want gen=%b done=%b",
                         e, gen_rst_n, seq_done, exp, exp[2]);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_sw_held;
        logic [2:0] exp;
        restart_main();
        for (int e = 1; e <= 38; e++) begin
            sw_rst_req = (e >= 20 && e <= 29);
            tick();
            exp = exp3(e, 20, 29);
            n_tests++;
            if (gen_rst_n !== exp || seq_done !== exp[2] || seq_busy !== !exp[2]) begin
                n_fail++;
                $display("FAIL sw_held edge %0d: gen=%b done=%b busy=%b, want gen=%b done=%b",
                         e, gen_rst_n, seq_done, seq_busy, exp, exp[2]);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_sweep;
        logic exp;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            sw2 = (e == 8);
            tick();
            exp = (e >= 4 && e < 8) || (e >= 9);
            n_tests++;
            if (gen2 !== exp || done2 !== exp || busy2 !== !exp) begin
                n_fail++;
                $display("FAIL sweep edge %0d: gen=%b done=%b busy=%b, want %b",
                         e, gen2, done2, busy2, exp);
            end
        end
        sw2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_mid();
        test_sw_single();
        test_sw_early();
        test_sw_held();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
